array_packed_3d_filler: RTL and testbench
=========================================

Name: array_packed_3d_filler

Overview:
Parametrised engine that fills a packed 3D register array `[D1-1:0][D2-1:0][D3-1:0][W-1:0]` one element per cycle.
- Traversal order: k innermost, then j, then i.
- Selectable value mode; ready-based stall; start/busy/done handshake.
- Serves as a reusable stimulus/waveform source for multi-dimensional packed-array dumps and as a generic table initialiser.

Parameters:
- D1, 4, size of outermost dimension (i)
- D2, 3, size of middle dimension (j)
- D3, 2, size of innermost dimension (k)
- W, 8, element width in bits

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a fill pass; sampled only in IDLE
- mode  in  2  value mode: 0=SUM (i+j+k), 1=LINEAR ((i*D2+j)*D3+k), 2=CONST (fill), 3=reserved (treated as CONST)
- fill  in  W  constant for CONST mode; latched with start
- ready  in  1  advance enable; 0 stalls traversal, no write
- busy  out  1  high while in RUN
- done  out  1  single-cycle pulse after last element written
- idx_i  out  $clog2(D1) (min 1)  current i index
- idx_j  out  $clog2(D2) (min 1)  current j index
- idx_k  out  $clog2(D3) (min 1)  current k index
- array  out  D1*D2*D3*W  packed array; element (i,j,k) at bits `[((i*D2+j)*D3+k)*W +: W]`

Behaviour:
- Reset (rst=1 at edge): state IDLE; array all zero; indices 0; busy=0; done=0; latched mode/fill = 0. Reset overrides any operation, including mid-pass.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1; latch mode and fill; indices cleared to 0.
  - RUN: each edge with ready=1 writes the element at the current (i,j,k) and advances indices.
    - k wraps D3-1 -> 0 and increments j.
    - j wraps D2-1 -> 0 and increments i.
  - RUN -> DONE on the edge that writes (D1-1, D2-1, D3-1). Indices return to 0.
  - DONE -> IDLE unconditionally after one cycle; done=1 only while in DONE.
- Latency: start at edge e0; writes at e1..eN with N=D1*D2*D3 when ready is held high; done visible in the cycle after eN; IDLE after eN+1.
- ready=0 in RUN: no write; indices, state and latched values held.
- start while in RUN or DONE: ignored. Mode/fill changes after latching: ignored.
- Array contents persist between passes; a new pass overwrites every element. There is no clear except rst.
- Arithmetic: value is computed at full integer width, then truncated to W LSBs (mod 2^W).
- Index outputs are registered and equal the element being written on the next enabled edge.
- D1, D2 or D3 = 1: the corresponding index stays 0; wrap logic degenerates correctly.

Decomposition:
- Package array_fill_pkg holds:
  - enum mode_t {SUM, LINEAR, CONST, RSVD}
  - enum state_t {IDLE, RUN, DONE}
  - width helper function `idx_w(n)`, returning max(1, $clog2(n))
- Sub-module idx_counter_3d: nested wrap counters with inputs clr and en, outputs i/j/k and last. last = all indices at maximum. The top level owns the FSM, value mux and array register.

Test Plan:
- Defaults, mode=SUM, ready=1, start pulse: busy for exactly 24 cycles; done pulse once at cycle 25; element[3][2][1]=6, [0][0][0]=0, [2][1][0]=3.
- mode=LINEAR, defaults: element[3][2][1]=23, [1][0][1]=7; flat bits [191:184]=0x17.
- mode=CONST, fill=0xA5, ready toggled 1/0 each cycle: all 24 elements = 0xA5; done after 48 write-opportunity cycles; indices frozen on every ready=0 cycle.
- W=4, mode=LINEAR: element[3][2][1]=23 mod 16=7, [2][0][0]=12. Confirms truncation.
- rst asserted after 10 writes of a SUM pass: next cycle array all zero, busy=0, indices 0, no done pulse. A following start completes a normal 24-cycle pass.
- start re-asserted during RUN and during DONE with mode=CONST: ignored; SUM values of the first pass intact; exactly one done pulse.

Source files
------------

// File: rtl/array_fill_pkg.sv
// Shared types and helpers for the packed 3D array filler.
//   mode_t  : value source selected when a pass is started
//   state_t : control FSM states
//   idx_w() : index width for a dimension of size n (never below 1 bit)
package array_fill_pkg;

  typedef enum logic [1:0] {
    SUM    = 2'd0,
    LINEAR = 2'd1,
    CONST  = 2'd2,
    RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/idx_counter_3d.sv
// Nested wrap counters walking (i, j, k) with k innermost.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : return all indices to 0
//   en       : advance one position
//   i, j, k  : current indices
//   last     : all indices at their maximum
module idx_counter_3d
  import array_fill_pkg::*;
#(
  parameter int D1 = 4,
  parameter int D2 = 3,
  parameter int D3 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [idx_w(D1)-1:0] i,
  output logic [idx_w(D2)-1:0] j,
  output logic [idx_w(D3)-1:0] k,
  output logic                 last
);

  localparam int IW = idx_w(D1);
  localparam int JW = idx_w(D2);
  localparam int KW = idx_w(D3);

  // With a dimension of size 1 the max is 0, so that index wraps on every
  // carry and simply stays at 0.
  localparam logic [IW-1:0] I_MAX = IW'(D1 - 1);
  localparam logic [JW-1:0] J_MAX = JW'(D2 - 1);
  localparam logic [KW-1:0] K_MAX = KW'(D3 - 1);

  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [KW-1:0] r_k;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (en) begin
      if (r_k == K_MAX) begin
        r_k <= '0;
        if (r_j == J_MAX) begin
          r_j <= '0;
          // Wrapping i on the final element leaves the counter at (0,0,0).
          r_i <= (r_i == I_MAX) ? '0 : r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign i    = r_i;
  assign j    = r_j;
  assign k    = r_k;
  assign last = (r_i == I_MAX) && (r_j == J_MAX) && (r_k == K_MAX);

endmodule

// File: rtl/array_packed_3d_filler.sv
// Fills a packed [D1][D2][D3][W] array one element per enabled cycle,
// k innermost, then j, then i.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a pass (honoured only in IDLE)
//   mode, fill          : value source and constant, latched with start
//   ready               : advance enable; low stalls the traversal
//   busy, done          : in RUN / single-cycle end-of-pass pulse
//   idx_i, idx_j, idx_k : element written on the next enabled edge
//   array               : element (i,j,k) at [((i*D2+j)*D3+k)*W +: W]
module array_packed_3d_filler
  import array_fill_pkg::*;
#(
  parameter int D1 = 4,
  parameter int D2 = 3,
  parameter int D3 = 2,
  parameter int W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [W-1:0]            fill,
  input  logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [idx_w(D1)-1:0]    idx_i,
  output logic [idx_w(D2)-1:0]    idx_j,
  output logic [idx_w(D3)-1:0]    idx_k,
  output logic [D1*D2*D3*W-1:0]   array
);

  localparam int N = D1 * D2 * D3;

  state_t         r_state;
  state_t         w_state_next;
  mode_t          r_mode;
  logic [W-1:0]   r_fill;
  logic [N*W-1:0] r_array;

  logic           w_clr;
  logic           w_wr;
  logic           w_last;
  int             w_lin;
  int             w_sum;
  logic [W-1:0]   w_value;

  idx_counter_3d #(
    .D1 (D1),
    .D2 (D2),
    .D3 (D3)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_wr),
    .i    (idx_i),
    .j    (idx_j),
    .k    (idx_k),
    .last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_clr        = 1'b1;
        end
      end
      RUN: begin
        if (ready) begin
          w_wr = 1'b1;
          if (w_last) begin
            w_state_next = DONE;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= SUM;
      r_fill <= '0;
    end else if (w_clr) begin
      r_mode <= mode_t'(mode);
      r_fill <= fill;
    end
  end

  // Values are formed at integer width and truncated to W bits. The linear
  // position doubles as the element's slot number in the flat array.
  assign w_lin = (int'(idx_i) * D2 + int'(idx_j)) * D3 + int'(idx_k);
  assign w_sum = int'(idx_i) + int'(idx_j) + int'(idx_k);

  always_comb begin
    w_value = r_fill;
    case (r_mode)
      SUM:     w_value = W'(w_sum);
      LINEAR:  w_value = W'(w_lin);
      default: w_value = r_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_array <= '0;
    end else if (w_wr) begin
      for (int n = 0; n < N; n++) begin
        if (w_lin == n) begin
          r_array[n*W +: W] <= w_value;
        end
      end
    end
  end

  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign array = r_array;

endmodule

// File: tb/tb_array_packed_3d_filler.sv
module tb_array_packed_3d_filler;

  localparam int D1 = 4;
  localparam int D2 = 3;
  localparam int D3 = 2;
  localparam int N  = D1 * D2 * D3;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [1:0]  mode  = 2'd0;
  logic [7:0]  fill  = 8'd0;

  logic        busy, done;
  logic [1:0]  idx_i, idx_j;
  logic [0:0]  idx_k;
  logic [191:0] arr8;

  logic        busy4, done4;
  logic [1:0]  idx_i4, idx_j4;
  logic [0:0]  idx_k4;
  logic [95:0] arr4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  array_packed_3d_filler #(.D1(D1), .D2(D2), .D3(D3), .W(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .fill  (fill),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .idx_i (idx_i),
    .idx_j (idx_j),
    .idx_k (idx_k),
    .array (arr8)
  );

  array_packed_3d_filler #(.D1(D1), .D2(D2), .D3(D3), .W(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .fill  (fill[3:0]),
    .ready (ready),
    .busy  (busy4),
    .done  (done4),
    .idx_i (idx_i4),
    .idx_j (idx_j4),
    .idx_k (idx_k4),
    .array (arr4)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] el8(input int i, input int j, input int k);
    logic [191:0] t;
    t = arr8 >> (((i * D2 + j) * D3 + k) * 8);
    return t[7:0];
  endfunction

  function automatic logic [3:0] el4(input int i, input int j, input int k);
    logic [95:0] t;
    t = arr4 >> (((i * D2 + j) * D3 + k) * 4);
    return t[3:0];
  endfunction

  // Expected full array: m=0 sum, m=1 linear position, otherwise constant f.
  function automatic logic [191:0] model8(input int m, input logic [7:0] f);
    logic [191:0] r;
    int v, p;
    r = '0;
    for (int i = 0; i < D1; i++)
      for (int j = 0; j < D2; j++)
        for (int k = 0; k < D3; k++) begin
          p = (i * D2 + j) * D3 + k;
          v = (m == 0) ? (i + j + k) : (m == 1) ? p : int'(f);
          r = r | (192'(v[7:0]) << (p * 8));
        end
    return r;
  endfunction

  function automatic logic [95:0] model4_linear();
    logic [95:0] r;
    int p;
    r = '0;
    for (p = 0; p < N; p++) r = r | (96'(p[3:0]) << (p * 4));
    return r;
  endfunction

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] f);
    start = 1'b1;
    mode  = m;
    fill  = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs from the cycle after the start edge until the FSM is back in IDLE.
  // toggle: ready low on odd cycles, high on even ones.
  // poke:   hold start high with CONST mode for the whole pass.
  task automatic run_pass(input bit toggle, input bit poke,
                          output int busy_cnt, output int done_cnt, output int done_cyc);
    int n;
    bit fin;
    n = 0; fin = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 150; c++) begin
      if (!busy && !done) begin
        fin = 1;
        break;
      end
      if (busy) begin
        busy_cnt++;
        check("idx_i", 192'(idx_i), 192'((n % N) / (D2 * D3)));
        check("idx_j", 192'(idx_j), 192'(((n % N) / D3) % D2));
        check("idx_k", 192'(idx_k), 192'(n % D3));
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
        check("idx_done", {186'd0, idx_i, idx_j, idx_k}, 192'd0);
      end
      ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (poke) begin
        start = 1'b1;
        mode  = 2'd2;
        fill  = 8'h3C;
      end
      if (busy && ready) n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b1;
    check("pass_finished", 192'(fin), 192'd1);
  endtask

  int b, d, dc;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 192'(busy), 192'd0);
    check("rst_done", 192'(done), 192'd0);
    check("rst_array", arr8, 192'd0);
    check("rst_idx", {186'd0, idx_i, idx_j, idx_k}, 192'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SUM pass, ready held high
    pulse_start(2'd0, 8'd0);
    run_pass(0, 0, b, d, dc);
    $display("pass SUM: busy=%0d done_pulses=%0d done_cycle=%0d", b, d, dc);
    check("sum_busy_cycles", 192'(b), 192'd24);
    check("sum_done_pulses", 192'(d), 192'd1);
    check("sum_done_cycle", 192'(dc), 192'd25);
    check("sum_e321", 192'(el8(3, 2, 1)), 192'd6);
    check("sum_e000", 192'(el8(0, 0, 0)), 192'd0);
    check("sum_e210", 192'(el8(2, 1, 0)), 192'd3);
    check("sum_array", arr8, model8(0, 8'd0));

    // LINEAR pass, both widths
    pulse_start(2'd1, 8'd0);
    run_pass(0, 0, b, d, dc);
    $display("pass LINEAR: busy=%0d done_pulses=%0d done_cycle=%0d", b, d, dc);
    check("lin_e321", 192'(el8(3, 2, 1)), 192'd23);
    check("lin_e101", 192'(el8(1, 0, 1)), 192'd7);
    check("lin_top_byte", 192'(arr8[191:184]), 192'h17);
    check("lin_array", arr8, model8(1, 8'd0));
    check("w4_e321", 192'(el4(3, 2, 1)), 192'd7);
    check("w4_e200", 192'(el4(2, 0, 0)), 192'd12);
    check("w4_array", 192'(arr4), 192'(model4_linear()));

    // CONST pass with ready toggling
    pulse_start(2'd2, 8'hA5);
    run_pass(1, 0, b, d, dc);
    $display("pass CONST toggled: busy=%0d done_pulses=%0d done_cycle=%0d", b, d, dc);
    check("const_busy_cycles", 192'(b), 192'd48);
    check("const_done_pulses", 192'(d), 192'd1);
    check("const_done_cycle", 192'(dc), 192'd49);
    check("const_array", arr8, {24{8'hA5}});

    // Reserved mode behaves as CONST
    pulse_start(2'd3, 8'h5A);
    run_pass(0, 0, b, d, dc);
    $display("pass RSVD: busy=%0d done_pulses=%0d done_cycle=%0d", b, d, dc);
    check("rsvd_array", arr8, {24{8'h5A}});

    // Reset in the middle of a SUM pass, after 10 writes
    pulse_start(2'd0, 8'd0);
    repeat (10) @(posedge clk);
    #1;
    check("mid_idx", {186'd0, idx_i, idx_j, idx_k}, {186'd0, 2'd1, 2'd2, 1'd0});
    check("mid_e111", 192'(el8(1, 1, 1)), 192'd3);
    check("mid_e120", 192'(el8(1, 2, 0)), 192'h5A);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("mid-pass reset applied");
    check("mrst_array", arr8, 192'd0);
    check("mrst_busy", 192'(busy), 192'd0);
    check("mrst_done", 192'(done), 192'd0);
    check("mrst_idx", {186'd0, idx_i, idx_j, idx_k}, 192'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_no_done", 192'(done), 192'd0);
    check("mrst_idle", 192'(busy), 192'd0);

    pulse_start(2'd0, 8'd0);
    run_pass(0, 0, b, d, dc);
    $display("pass SUM after reset: busy=%0d done_pulses=%0d done_cycle=%0d", b, d, dc);
    check("post_rst_busy_cycles", 192'(b), 192'd24);
    check("post_rst_done_pulses", 192'(d), 192'd1);
    check("post_rst_array", arr8, model8(0, 8'd0));

    // Fill with LINEAR, then a SUM pass with start hammered throughout
    pulse_start(2'd1, 8'd0);
    run_pass(0, 0, b, d, dc);
    pulse_start(2'd0, 8'd0);
    run_pass(0, 1, b, d, dc);
    $display("pass SUM with start held: busy=%0d done_pulses=%0d done_cycle=%0d", b, d, dc);
    check("ign_busy_cycles", 192'(b), 192'd24);
    check("ign_done_pulses", 192'(d), 192'd1);
    check("ign_array", arr8, model8(0, 8'd0));
    repeat (3) @(posedge clk);
    #1;
    check("ign_stays_idle", {190'd0, busy, done}, 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
